math_round_ctrl: RTL and testbench
==================================

Name: math_round_ctrl

Overview:
- Round sequencer for the two-player math game.
- Once access is granted and start is pressed, it:
  - draws a random operand,
  - waits for player 2 to load a guess, with a per-round timeout,
  - checks the adder sum against the target,
  - pulses the scoreboard on a hit,
  - ends the game after MAX_ROUNDS rounds or when the global game timer expires.
- Drives the random generator enable, the load-register enable, the scoreboard increment and clear, and the two-digit timer reload and run.

Parameters:
- W, 4: data width of the operand, guess and sum.
- TARGET, 15: sum value that scores a hit.
- MAX_ROUNDS, 9: rounds per game (1..15).
- ROUND_SECS, 5: one-second ticks allowed per round before a miss (1..15).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- access_ok, input, 1: level from the access controller; password accepted.
- start, input, 1: one-cycle pulse from the button shaper.
- load_p, input, 1: one-cycle pulse from the button shaper; player 2 loads a guess.
- sum, input, W: combinational adder output (operand + loaded guess).
- tick, input, 1: one-cycle pulse per second from the one-second timer.
- timer_zero, input, 1: level; the two-digit game timer has reached 00.
- rng_en, output, 1: advance the random generator (one-cycle pulse).
- ld_en, output, 1: load-register enable (one-cycle pulse).
- score_inc, output, 1: scoreboard increment (one-cycle pulse).
- score_clr, output, 1: scoreboard clear (one-cycle pulse).
- timer_reload, output, 1: reload the two-digit timer from its switches (one-cycle pulse).
- timer_run, output, 1: enable the game-timer countdown.
- round_cnt, output, 4: current round number (1-based; 0 when idle).
- secs_left, output, 4: remaining seconds in the current round.
- misses, output, 4: timed-out plus wrong rounds, saturating at 15.
- game_over, output, 1: high while in the OVER state.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - round_cnt, secs_left and misses are 0.
  - All outputs are 0.
  - rst overrides every other input.
- States: IDLE, DRAW, WAIT_LOAD, CHECK, OVER. State is binary-encoded and outputs are decoded from state.
- Abort: access_ok=0 in any state other than IDLE returns to IDLE on the next edge. round_cnt and secs_left clear; misses is kept.
- IDLE:
  - If access_ok && start: assert score_clr=1 and timer_reload=1 combinationally for that cycle, clear misses, and go to DRAW.
- DRAW (exactly 1 cycle):
  - rng_en=1.
  - round_cnt <= round_cnt+1.
  - secs_left <= ROUND_SECS.
  - Next state is WAIT_LOAD.
- WAIT_LOAD (timer_run=1). Evaluate in this priority order, highest first:
  1. timer_zero=1: go to OVER.
  2. load_p=1: ld_en=1 this cycle and go to CHECK. The guess register captures on this same edge.
  3. tick=1 and secs_left==1: misses+1, secs_left <= 0, then go to OVER if round_cnt==MAX_ROUNDS, else DRAW.
  4. tick=1 (other cases): secs_left-1.
- CHECK (1 cycle, timer_run=1):
  - sum already reflects the new guess in this cycle.
  - If sum==TARGET: score_inc=1. Otherwise misses+1.
  - Next state is OVER if round_cnt==MAX_ROUNDS, else DRAW.
  - timer_zero in CHECK is ignored for that cycle and takes effect in the next WAIT_LOAD.
- OVER:
  - game_over=1 and timer_run=0.
  - start pulse goes to IDLE; round_cnt clears.
- Width and arithmetic rules:
  - misses saturates at 15.
  - round_cnt never exceeds MAX_ROUNDS.
  - Sum comparison is exact on W bits. The adder's 4-bit wrap is not a hit unless it equals TARGET.
- Stray pulses:
  - start outside IDLE and OVER is ignored.
  - load_p outside WAIT_LOAD gives no ld_en.
  - tick outside WAIT_LOAD has no effect.
- Latency:
  - start to rng_en: 1 cycle.
  - load_p to score_inc: 1 cycle.

Decomposition:
- Package math_game_pkg holds:
  - the state enum (IDLE, DRAW, WAIT_LOAD, CHECK, OVER),
  - the defaults for W, TARGET, MAX_ROUNDS and ROUND_SECS,
  - the 4-bit saturating-increment function shared with the scoreboard.
- One natural sub-module, round_timeout: a 4-bit down-counter with load (ROUND_SECS), decrement on tick, and an expire flag when secs_left==1 && tick. The FSM instantiates it.

Test Plan:
- Reset and gating:
  - Stimulus: rst=1, then access_ok=0 and a start pulse.
  - Response: stays IDLE, every output 0, no rng_en.
- Hit path:
  - Stimulus: access_ok=1 and start; then load_p with sum forced to 15 in the next cycle.
  - Response: score_clr and timer_reload pulse in the start cycle; rng_en one cycle later; round_cnt=1; ld_en coincident with load_p; score_inc=1 exactly once in the CHECK cycle; rng_en again for round 2.
- Miss by wrong sum:
  - Stimulus: load_p with sum=12.
  - Response: score_inc=0, misses=1, round_cnt advances to 2.
- Round timeout:
  - Stimulus: in WAIT_LOAD, 5 tick pulses and no load_p.
  - Response: secs_left reads 5,4,3,2,1, then 0 on the 5th tick; misses+1; DRAW follows.
- Game end by rounds:
  - Stimulus: 9 rounds with sum=15, then a start pulse in OVER.
  - Response: 9 score_inc pulses; OVER after CHECK of round 9 with game_over=1 and timer_run=0; the start pulse gives IDLE and round_cnt=0.
- Priorities and abort:
  - Stimulus A: timer_zero, load_p and tick asserted in the same WAIT_LOAD cycle. Response: OVER, no ld_en.
  - Stimulus B: access_ok dropped in WAIT_LOAD. Response: IDLE next cycle, round_cnt=0.

Source files
------------

// File: rtl/math_game_pkg.sv
// Shared types, default parameters and helpers for the two-player math game.
package math_game_pkg;

  // Round sequencer states, binary encoded.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StDraw     = 3'd1,
    StWaitLoad = 3'd2,
    StCheck    = 3'd3,
    StOver     = 3'd4
  } state_e;

  localparam int unsigned DefW          = 4;
  localparam int unsigned DefTarget     = 15;
  localparam int unsigned DefMaxRounds  = 9;
  localparam int unsigned DefRoundSecs  = 5;

  // 4-bit increment that sticks at 15; also used by the scoreboard.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/math_round_ctrl_if.sv
// Control/status bundle between the round sequencer and the rest of the game.
interface math_round_ctrl_if #(
  parameter int unsigned W = 4
) ();
  logic         access_ok;
  logic         start;
  logic         load_p;
  logic [W-1:0] sum;
  logic         tick;
  logic         timer_zero;
  logic         rng_en;
  logic         ld_en;
  logic         score_inc;
  logic         score_clr;
  logic         timer_reload;
  logic         timer_run;
  logic [3:0]   round_cnt;
  logic [3:0]   secs_left;
  logic [3:0]   misses;
  logic         game_over;

  // Game-side view: drives buttons/status, receives control strobes.
  modport master (
    output access_ok, start, load_p, sum, tick, timer_zero,
    input  rng_en, ld_en, score_inc, score_clr, timer_reload, timer_run,
    input  round_cnt, secs_left, misses, game_over
  );

  // Sequencer view.
  modport slave (
    input  access_ok, start, load_p, sum, tick, timer_zero,
    output rng_en, ld_en, score_inc, score_clr, timer_reload, timer_run,
    output round_cnt, secs_left, misses, game_over
  );
endinterface

// File: rtl/round_timeout.sv
// Per-round seconds down-counter: loads ROUND_SECS, counts ticks, flags expiry.
module round_timeout #(
  parameter int unsigned ROUND_SECS = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic       en_i,
  input  logic       tick_i,
  output logic [3:0] secs_o,
  output logic       expire_o
);

  localparam logic [3:0] RoundSecs = 4'(ROUND_SECS);

  logic [3:0] secs_q, secs_d;

  // Clear wins over load, load wins over a counted tick; never wraps below 0.
  always_comb begin
    secs_d = secs_q;
    if (clr_i) begin
      secs_d = 4'd0;
    end else if (load_i) begin
      secs_d = RoundSecs;
    end else if (en_i && tick_i && (secs_q != 4'd0)) begin
      secs_d = secs_q - 4'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      secs_q <= 4'd0;
    end else begin
      secs_q <= secs_d;
    end
  end

  assign secs_o   = secs_q;
  assign expire_o = en_i && tick_i && (secs_q == 4'd1);

endmodule

// File: rtl/math_round_ctrl.sv
// Round sequencer: draws operands, times each guess, scores, ends the game.
module math_round_ctrl
  import math_game_pkg::*;
#(
  parameter int unsigned W          = DefW,
  parameter int unsigned TARGET     = DefTarget,
  parameter int unsigned MAX_ROUNDS = DefMaxRounds,
  parameter int unsigned ROUND_SECS = DefRoundSecs
) (
  input  logic              clk,
  input  logic              rst,
  math_round_ctrl_if.slave  bus
);

  localparam logic [W-1:0] Target    = W'(TARGET);
  localparam logic [3:0]   MaxRounds = 4'(MAX_ROUNDS);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] misses_q, misses_d;

  logic       to_clr, to_load, to_en, expire;
  logic [3:0] secs_left;
  logic       abort, last_round;

  logic rng_en, ld_en, score_inc, score_clr, timer_reload;

  assign abort      = (state_q != StIdle) && !bus.access_ok;
  assign last_round = (round_q == MaxRounds);

  // Ticks only count when nothing of higher priority happens in WAIT_LOAD.
  assign to_en = !rst && (state_q == StWaitLoad) && bus.access_ok &&
                 !bus.timer_zero && !bus.load_p;

  round_timeout #(
    .ROUND_SECS (ROUND_SECS)
  ) u_round_timeout (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (to_clr),
    .load_i   (to_load),
    .en_i     (to_en),
    .tick_i   (bus.tick),
    .secs_o   (secs_left),
    .expire_o (expire)
  );

  // Next-state, counter updates and strobe decode; abort beats everything but reset.
  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    misses_d     = misses_q;
    to_clr       = 1'b0;
    to_load      = 1'b0;
    rng_en       = 1'b0;
    ld_en        = 1'b0;
    score_inc    = 1'b0;
    score_clr    = 1'b0;
    timer_reload = 1'b0;
    if (rst) begin
      state_d = StIdle;
    end else if (abort) begin
      state_d = StIdle;
      round_d = 4'd0;
      to_clr  = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.access_ok && bus.start) begin
            score_clr    = 1'b1;
            timer_reload = 1'b1;
            misses_d     = 4'd0;
            state_d      = StDraw;
          end
        end
        StDraw: begin
          rng_en  = 1'b1;
          to_load = 1'b1;
          if (round_q < MaxRounds) begin
            round_d = round_q + 4'd1;
          end
          state_d = StWaitLoad;
        end
        StWaitLoad: begin
          if (bus.timer_zero) begin
            state_d = StOver;
          end else if (bus.load_p) begin
            ld_en   = 1'b1;
            state_d = StCheck;
          end else if (expire) begin
            misses_d = sat_inc4(misses_q);
            state_d  = last_round ? StOver : StDraw;
          end
        end
        StCheck: begin
          if (bus.sum == Target) begin
            score_inc = 1'b1;
          end else begin
            misses_d = sat_inc4(misses_q);
          end
          state_d = last_round ? StOver : StDraw;
        end
        StOver: begin
          if (bus.start) begin
            state_d = StIdle;
            round_d = 4'd0;
            to_clr  = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          round_d = 4'd0;
          to_clr  = 1'b1;
        end
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      round_q  <= 4'd0;
      misses_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      misses_q <= misses_d;
    end
  end

  assign bus.rng_en       = rng_en;
  assign bus.ld_en        = ld_en;
  assign bus.score_inc    = score_inc;
  assign bus.score_clr    = score_clr;
  assign bus.timer_reload = timer_reload;
  assign bus.timer_run    = !rst && ((state_q == StWaitLoad) || (state_q == StCheck));
  assign bus.game_over    = !rst && (state_q == StOver);
  assign bus.round_cnt    = round_q;
  assign bus.secs_left    = secs_left;
  assign bus.misses       = misses_q;

endmodule

// File: tb/tb_math_round_ctrl.sv
// Self-checking bench for math_round_ctrl with a score_inc scoreboard.
module tb_math_round_ctrl;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  math_round_ctrl_if #(.W(4)) bus ();

  math_round_ctrl #(
    .W          (4),
    .TARGET     (15),
    .MAX_ROUNDS (9),
    .ROUND_SECS (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected score_inc for every accepted guess, pushed when load_p is driven.
  logic exp_q[$];
  logic mon_en = 1'b0;
  logic ld_seen = 1'b0;

  // Monitor: the cycle after ld_en is the CHECK cycle; compare score_inc there.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ld_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got ld_en with no queued guess");
        end else begin
          logic e;
          e = exp_q.pop_front();
          if (bus.score_inc !== e) begin
            errors++;
            $display("FAIL sb_score_inc: got %b want %b", bus.score_inc, e);
          end
        end
      end else if (bus.score_inc !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL sb_spurious_score_inc: got %b want 0", bus.score_inc);
      end
      ld_seen = (bus.ld_en === 1'b1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Abort to IDLE, then start a fresh game; returns in WAIT_LOAD of round 1.
  task automatic new_game();
    bus.access_ok  = 1'b0;
    bus.start      = 1'b0;
    bus.load_p     = 1'b0;
    bus.tick       = 1'b0;
    bus.timer_zero = 1'b0;
    cyc();
    bus.access_ok = 1'b1;
    bus.start     = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    logic [19:0] outs;
    rst            = 1'b1;
    bus.access_ok  = 1'b0;
    bus.start      = 1'b0;
    bus.load_p     = 1'b0;
    bus.sum        = 4'd0;
    bus.tick       = 1'b0;
    bus.timer_zero = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    bus.start = 1'b1;
    #1;
    checks++;
    if (bus.score_clr !== 1'b0 || bus.timer_reload !== 1'b0) begin
      errors++;
      $display("FAIL reset_gated_start: got clr=%b reload=%b want 0 0",
               bus.score_clr, bus.timer_reload);
    end
    cyc();
    bus.start = 1'b0;
    mon_en = 1'b1;
    #1;
    outs = {bus.rng_en, bus.ld_en, bus.score_inc, bus.score_clr, bus.timer_reload,
            bus.timer_run, bus.round_cnt, bus.secs_left, bus.misses, bus.game_over};
    checks++;
    if (outs !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 00000", outs);
    end
  endtask

  task automatic test_hit();
    bus.access_ok = 1'b1;
    bus.start     = 1'b1;
    #1;
    checks++;
    if (bus.score_clr !== 1'b1 || bus.timer_reload !== 1'b1 || bus.rng_en !== 1'b0) begin
      errors++;
      $display("FAIL hit_start_pulses: got clr=%b reload=%b rng=%b want 1 1 0",
               bus.score_clr, bus.timer_reload, bus.rng_en);
    end
    cyc();
    bus.start = 1'b0;
    #1;
    checks++;
    if (bus.rng_en !== 1'b1) begin
      errors++;
      $display("FAIL hit_rng_en: got %b want 1", bus.rng_en);
    end
    cyc();
    #1;
    checks++;
    if (bus.round_cnt !== 4'd1 || bus.secs_left !== 4'd5 || bus.timer_run !== 1'b1) begin
      errors++;
      $display("FAIL hit_wait_load: got round=%0d secs=%0d run=%b want 1 5 1",
               bus.round_cnt, bus.secs_left, bus.timer_run);
    end
    bus.load_p = 1'b1;
    exp_q.push_back(1'b1);
    #1;
    checks++;
    if (bus.ld_en !== 1'b1) begin
      errors++;
      $display("FAIL hit_ld_en: got %b want 1", bus.ld_en);
    end
    cyc();
    bus.load_p = 1'b0;
    bus.sum    = 4'd15;
    #1;
    checks++;
    if (bus.score_inc !== 1'b1 || bus.ld_en !== 1'b0) begin
      errors++;
      $display("FAIL hit_check: got inc=%b ld=%b want 1 0", bus.score_inc, bus.ld_en);
    end
    cyc();
    #1;
    checks++;
    if (bus.rng_en !== 1'b1 || bus.misses !== 4'd0 || bus.score_inc !== 1'b0) begin
      errors++;
      $display("FAIL hit_round2_draw: got rng=%b misses=%0d inc=%b want 1 0 0",
               bus.rng_en, bus.misses, bus.score_inc);
    end
    cyc();
    #1;
    checks++;
    if (bus.round_cnt !== 4'd2) begin
      errors++;
      $display("FAIL hit_round2: got %0d want 2", bus.round_cnt);
    end
  endtask

  task automatic test_miss();
    new_game();
    bus.load_p = 1'b1;
    exp_q.push_back(1'b0);
    cyc();
    bus.load_p = 1'b0;
    bus.sum    = 4'd12;
    #1;
    checks++;
    if (bus.score_inc !== 1'b0) begin
      errors++;
      $display("FAIL miss_score_inc: got %b want 0", bus.score_inc);
    end
    cyc();
    #1;
    checks++;
    if (bus.misses !== 4'd1) begin
      errors++;
      $display("FAIL miss_count: got %0d want 1", bus.misses);
    end
    cyc();
    #1;
    checks++;
    if (bus.round_cnt !== 4'd2) begin
      errors++;
      $display("FAIL miss_round: got %0d want 2", bus.round_cnt);
    end
    // 4-bit wrap of the adder (15+1 -> 0) is a miss.
    bus.load_p = 1'b1;
    exp_q.push_back(1'b0);
    cyc();
    bus.load_p = 1'b0;
    bus.sum    = 4'd0;
    cyc();
    #1;
    checks++;
    if (bus.misses !== 4'd2) begin
      errors++;
      $display("FAIL miss_wrap: got %0d want 2", bus.misses);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] want;
    new_game();
    #1;
    checks++;
    if (bus.secs_left !== 4'd5) begin
      errors++;
      $display("FAIL timeout_start: got %0d want 5", bus.secs_left);
    end
    for (int i = 0; i < 5; i++) begin
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      #1;
      want = 4'(4 - i);
      checks++;
      if (bus.secs_left !== want) begin
        errors++;
        $display("FAIL timeout_secs_%0d: got %0d want %0d", i, bus.secs_left, want);
      end
    end
    checks++;
    if (bus.rng_en !== 1'b1 || bus.misses !== 4'd1) begin
      errors++;
      $display("FAIL timeout_draw: got rng=%b misses=%0d want 1 1", bus.rng_en, bus.misses);
    end
    // Stray load_p and tick in DRAW do nothing.
    bus.load_p = 1'b1;
    bus.tick   = 1'b1;
    #1;
    checks++;
    if (bus.ld_en !== 1'b0) begin
      errors++;
      $display("FAIL stray_load_ld_en: got %b want 0", bus.ld_en);
    end
    cyc();
    bus.load_p = 1'b0;
    bus.tick   = 1'b0;
    #1;
    checks++;
    if (bus.secs_left !== 4'd5 || bus.round_cnt !== 4'd2 || bus.timer_run !== 1'b1) begin
      errors++;
      $display("FAIL stray_after_draw: got secs=%0d round=%0d run=%b want 5 2 1",
               bus.secs_left, bus.round_cnt, bus.timer_run);
    end
  endtask

  task automatic test_game_end();
    int hits = 0;
    new_game();
    for (int r = 1; r <= 9; r++) begin
      bus.load_p = 1'b1;
      exp_q.push_back(1'b1);
      cyc();
      bus.load_p = 1'b0;
      bus.sum    = 4'd15;
      #1;
      if (bus.score_inc === 1'b1) hits++;
      cyc();
      if (r < 9) cyc();
    end
    checks++;
    if (hits != 9) begin
      errors++;
      $display("FAIL end_hits: got %0d want 9", hits);
    end
    #1;
    checks++;
    if (bus.game_over !== 1'b1 || bus.timer_run !== 1'b0 || bus.round_cnt !== 4'd9) begin
      errors++;
      $display("FAIL end_over: got over=%b run=%b round=%0d want 1 0 9",
               bus.game_over, bus.timer_run, bus.round_cnt);
    end
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    #1;
    checks++;
    if (bus.game_over !== 1'b0 || bus.round_cnt !== 4'd0 || bus.rng_en !== 1'b0) begin
      errors++;
      $display("FAIL end_to_idle: got over=%b round=%0d rng=%b want 0 0 0",
               bus.game_over, bus.round_cnt, bus.rng_en);
    end
  endtask

  task automatic test_priority_abort();
    // A: timer_zero beats load_p and tick.
    new_game();
    bus.timer_zero = 1'b1;
    bus.load_p     = 1'b1;
    bus.tick       = 1'b1;
    #1;
    checks++;
    if (bus.ld_en !== 1'b0) begin
      errors++;
      $display("FAIL prio_ld_en: got %b want 0", bus.ld_en);
    end
    cyc();
    bus.timer_zero = 1'b0;
    bus.load_p     = 1'b0;
    bus.tick       = 1'b0;
    #1;
    checks++;
    if (bus.game_over !== 1'b1 || bus.timer_run !== 1'b0 || bus.secs_left !== 4'd5) begin
      errors++;
      $display("FAIL prio_over: got over=%b run=%b secs=%0d want 1 0 5",
               bus.game_over, bus.timer_run, bus.secs_left);
    end
    // Stray start in WAIT_LOAD is ignored.
    new_game();
    bus.start = 1'b1;
    #1;
    checks++;
    if (bus.score_clr !== 1'b0) begin
      errors++;
      $display("FAIL stray_start_clr: got %b want 0", bus.score_clr);
    end
    cyc();
    bus.start = 1'b0;
    #1;
    checks++;
    if (bus.timer_run !== 1'b1 || bus.round_cnt !== 4'd1) begin
      errors++;
      $display("FAIL stray_start_state: got run=%b round=%0d want 1 1",
               bus.timer_run, bus.round_cnt);
    end
    // timer_zero during CHECK is deferred to the next WAIT_LOAD.
    bus.load_p = 1'b1;
    exp_q.push_back(1'b1);
    cyc();
    bus.load_p     = 1'b0;
    bus.sum        = 4'd15;
    bus.timer_zero = 1'b1;
    cyc();
    #1;
    checks++;
    if (bus.rng_en !== 1'b1 || bus.game_over !== 1'b0) begin
      errors++;
      $display("FAIL tz_in_check: got rng=%b over=%b want 1 0", bus.rng_en, bus.game_over);
    end
    cyc();
    cyc();
    bus.timer_zero = 1'b0;
    #1;
    checks++;
    if (bus.game_over !== 1'b1) begin
      errors++;
      $display("FAIL tz_next_wait: got %b want 1", bus.game_over);
    end
    // B: access_ok dropped in WAIT_LOAD aborts but keeps misses.
    new_game();
    bus.load_p = 1'b1;
    exp_q.push_back(1'b0);
    cyc();
    bus.load_p = 1'b0;
    bus.sum    = 4'd12;
    cyc();
    cyc();
    bus.access_ok = 1'b0;
    cyc();
    #1;
    checks++;
    if (bus.round_cnt !== 4'd0 || bus.timer_run !== 1'b0 || bus.misses !== 4'd1 ||
        bus.secs_left !== 4'd0 || bus.game_over !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got round=%0d run=%b misses=%0d secs=%0d over=%b",
               bus.round_cnt, bus.timer_run, bus.misses, bus.secs_left, bus.game_over);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_timeout();
    test_game_end();
    test_priority_abort();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
